// File: rtl/uart_boot_loader_if.sv
// Bus between the UART receiver / instruction memory side and the boot
// sequencer. The DUT takes the slave view; the bench or SoC glue takes master.
interface uart_boot_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  reload;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  cpu_run;
  logic                  busy;
  logic                  err;
  logic [7:0]            loaded_words;

  modport master (
    output rx_valid, rx_data, reload,
    input  mem_we, mem_addr, mem_wdata, cpu_run, busy, err, loaded_words
  );

  modport slave (
    input  rx_valid, rx_data, reload,
    output mem_we, mem_addr, mem_wdata, cpu_run, busy, err, loaded_words
  );
endinterface

// File: rtl/uart_boot_loader.sv
// Boot sequencer: holds the core halted, receives a framed image
// (magic, word count, LSB-first data bytes, XOR checksum) from the UART,
// writes each assembled word to instruction memory and releases the core
// only when the checksum matches.
module uart_boot_loader #(
  parameter int         DATA_WIDTH     = 32,
  parameter int         ADDR_WIDTH     = 8,
  parameter int         TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0] MAGIC          = 8'hA5
) (
  input logic               clk,
  input logic               reset,
  uart_boot_loader_if.slave bus
);
  // Word counter is one bit wider than the address so a full 2**ADDR_WIDTH
  // image can be counted; it is never narrower than the 8-bit count byte.
  localparam int CW = (ADDR_WIDTH > 8) ? ADDR_WIDTH + 1 : 9;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_MAGIC, S_COUNT, S_DATA, S_CHECK, S_RUN, S_ERROR} state_t;

  state_t                state, state_nx;
  logic [1:0]            byte_idx;
  logic [CW-1:0]         word_idx;
  logic [7:0]            n_words;
  logic [7:0]            chk;
  logic [31:0]           wbuf;
  logic [TW-1:0]         tmo;
  logic                  mem_we_q, cpu_run_q, err_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [7:0]            loaded_q;

  logic busy_st, tmo_hit, cnt_bad, last_word, is_magic;

  assign busy_st   = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
  assign tmo_hit   = busy_st && !bus.rx_valid && (tmo == TW'(TIMEOUT_CYCLES - 1));
  assign cnt_bad   = (bus.rx_data == 8'd0) ||
                     ({24'd0, bus.rx_data} > (32'd1 << ADDR_WIDTH));
  assign last_word = (word_idx == (CW'(n_words) - CW'(1)));
  assign is_magic  = (bus.rx_data == MAGIC);

  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.cpu_run      = cpu_run_q;
  assign bus.busy         = busy_st;
  assign bus.err          = err_q;
  assign bus.loaded_words = loaded_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_MAGIC;
    else        state <= state_nx;
  end

  // Next state: reload beats everything (the coincident byte is dropped),
  // then the inter-byte timeout, then the received byte.
  always_comb begin
    state_nx = state;
    if (bus.reload) state_nx = S_MAGIC;
    else if (tmo_hit) state_nx = S_ERROR;
    else if (bus.rx_valid) begin
      case (state)
        S_MAGIC, S_ERROR: if (is_magic) state_nx = S_COUNT;
        S_COUNT:          state_nx = cnt_bad ? S_ERROR : S_DATA;
        S_DATA:           if (byte_idx == 2'd3 && last_word) state_nx = S_CHECK;
        S_CHECK:          state_nx = (bus.rx_data == chk) ? S_RUN : S_ERROR;
        default:          ;
      endcase
    end
  end

  // Datapath: word assembly, memory write strobe, checksum, timeout, flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx    <= '0;
      word_idx    <= '0;
      n_words     <= '0;
      chk         <= '0;
      wbuf        <= '0;
      tmo         <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_run_q   <= 1'b0;
      err_q       <= 1'b0;
      loaded_q    <= '0;
    end else begin
      mem_we_q  <= 1'b0;
      // Tracks the state register so the core runs exactly while in S_RUN.
      cpu_run_q <= (state_nx == S_RUN);
      if (state_nx == S_ERROR && state != S_ERROR) err_q <= 1'b1;

      if (bus.rx_valid || !busy_st) tmo <= '0;
      else                          tmo <= tmo + TW'(1);

      if (bus.rx_valid && !bus.reload) begin
        case (state)
          S_MAGIC, S_ERROR: if (is_magic) begin
            err_q <= 1'b0;
            chk   <= '0;
          end
          S_COUNT: if (!cnt_bad) begin
            n_words  <= bus.rx_data;
            word_idx <= '0;
            byte_idx <= '0;
          end
          S_DATA: begin
            chk                  <= chk ^ bus.rx_data;
            byte_idx             <= byte_idx + 2'd1;
            wbuf[byte_idx*8 +: 8] <= bus.rx_data;
            if (byte_idx == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_idx[ADDR_WIDTH-1:0];
              mem_wdata_q <= {bus.rx_data, wbuf[23:0]};
              word_idx    <= word_idx + CW'(1);
            end
          end
          S_CHECK: if (bus.rx_data == chk) loaded_q <= n_words;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: frames are driven byte by byte, expected
// memory writes go into a scoreboard queue and are matched against the
// writes captured from the memory port.
module tb_uart_boot_loader;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 200;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_boot_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  uart_boot_loader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO), .MAGIC(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] obs[0:1023];
  int               wr_cnt = 0;
  int               rd_ptr = 0;
  logic [AW+DW-1:0] e;

  // Capture every cycle the write strobe is high; a stretched strobe shows
  // up as an extra write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1 && wr_cnt < 1024) begin
      obs[wr_cnt] = {bus.mem_addr, bus.mem_wdata};
      wr_cnt      = wr_cnt + 1;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reload();
    bus.reload = 1'b1;
    @(negedge clk);
    bus.reload = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w[$], input logic [7:0] chk_flip);
    logic [7:0] c = 8'h00;
    send_byte(8'hA5);
    send_byte(8'(w.size()));
    foreach (w[i]) begin
      exp_q.push_back({8'(i), w[i]});
      for (int b = 0; b < 4; b++) begin
        c ^= w[i][b*8 +: 8];
        send_byte(w[i][b*8 +: 8]);
      end
    end
    send_byte(c ^ chk_flip);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.reload   = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.mem_we, bus.cpu_run, bus.busy, bus.err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 0000",
                         {bus.mem_we, bus.cpu_run, bus.busy, bus.err});
    end
    n_chk++;
    if ({bus.loaded_words, bus.mem_addr, bus.mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_values: got %h required 0",
                         {bus.loaded_words, bus.mem_addr, bus.mem_wdata});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_frame();
    logic [31:0] w[$];
    // Checksum of this image is 0x2A (XOR of the eight data bytes).
    w = '{32'h12345678, 32'hDEADBEEF};
    send_frame(w, 8'h00);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_chk++;
      if (rd_ptr >= wr_cnt) begin n_fail++; $display("FAIL good_write: none, required %h", e); end
      else begin
        if (obs[rd_ptr] !== e) begin n_fail++; $display("FAIL good_write: got %h required %h", obs[rd_ptr], e); end
        rd_ptr++;
      end
    end
    n_chk++;
    if (wr_cnt != rd_ptr) begin n_fail++; $display("FAIL good_extra: %0d extra writes, required 0", wr_cnt - rd_ptr); rd_ptr = wr_cnt; end
    n_chk++;
    if ({bus.cpu_run, bus.err, bus.busy} !== 3'b100) begin
      n_fail++; $display("FAIL good_status: run/err/busy %b required 100", {bus.cpu_run, bus.err, bus.busy});
    end
    n_chk++;
    if (bus.loaded_words !== 8'd2) begin n_fail++; $display("FAIL good_loaded: got %0d required 2", bus.loaded_words); end
  endtask

  task automatic test_bad_checksum();
    logic [31:0] w[$];
    pulse_reload();
    w = '{32'h12345678, 32'hDEADBEEF};
    send_frame(w, 8'h01);
    n_chk++;
    if ({bus.cpu_run, bus.err} !== 2'b01) begin
      n_fail++; $display("FAIL badchk_status: run/err %b required 01", {bus.cpu_run, bus.err});
    end
    n_chk++;
    if (bus.loaded_words !== 8'd2) begin n_fail++; $display("FAIL badchk_loaded: got %0d required 2", bus.loaded_words); end
    w = '{32'hCAFEF00D, 32'h01020304, 32'hA5A5A5A5};
    send_frame(w, 8'h00);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_chk++;
      if (rd_ptr >= wr_cnt) begin n_fail++; $display("FAIL badchk_write: none, required %h", e); end
      else begin
        if (obs[rd_ptr] !== e) begin n_fail++; $display("FAIL badchk_write: got %h required %h", obs[rd_ptr], e); end
        rd_ptr++;
      end
    end
    n_chk++;
    if (wr_cnt != rd_ptr) begin n_fail++; $display("FAIL badchk_extra: %0d extra writes, required 0", wr_cnt - rd_ptr); rd_ptr = wr_cnt; end
    n_chk++;
    if ({bus.cpu_run, bus.err, bus.loaded_words} !== {2'b10, 8'd3}) begin
      n_fail++; $display("FAIL recover_status: run/err/loaded %b/%b/%0d required 1/0/3",
                         bus.cpu_run, bus.err, bus.loaded_words);
    end
  endtask

  task automatic test_count_bounds();
    logic [31:0] w[$];
    pulse_reload();
    send_byte(8'hA5);
    send_byte(8'h00);
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bus.err, bus.busy, bus.cpu_run} !== 3'b100) begin
      n_fail++; $display("FAIL count0_status: err/busy/run %b required 100", {bus.err, bus.busy, bus.cpu_run});
    end
    n_chk++;
    if (wr_cnt != rd_ptr) begin n_fail++; $display("FAIL count0_write: %0d writes, required 0", wr_cnt - rd_ptr); rd_ptr = wr_cnt; end
    w = '{32'h0BADF00D};
    send_frame(w, 8'h00);
    n_chk++;
    if ({bus.cpu_run, bus.err, bus.loaded_words} !== {2'b10, 8'd1}) begin
      n_fail++; $display("FAIL count1_status: run/err/loaded %b/%b/%0d required 1/0/1",
                         bus.cpu_run, bus.err, bus.loaded_words);
    end
    // Largest count the 8-bit count byte can carry.
    pulse_reload();
    w = {};
    for (int i = 0; i < 255; i++) w.push_back($urandom);
    send_frame(w, 8'h00);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_chk++;
      if (rd_ptr >= wr_cnt) begin n_fail++; $display("FAIL count_write: none, required %h", e); end
      else begin
        if (obs[rd_ptr] !== e) begin n_fail++; $display("FAIL count_write: got %h required %h", obs[rd_ptr], e); end
        rd_ptr++;
      end
    end
    n_chk++;
    if (wr_cnt != rd_ptr) begin n_fail++; $display("FAIL count_extra: %0d extra writes, required 0", wr_cnt - rd_ptr); rd_ptr = wr_cnt; end
    n_chk++;
    if ({bus.cpu_run, bus.loaded_words} !== {1'b1, 8'd255}) begin
      n_fail++; $display("FAIL count255_status: run/loaded %b/%0d required 1/255", bus.cpu_run, bus.loaded_words);
    end
  endtask

  task automatic test_timeout();
    pulse_reload();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (TMO - 6) @(negedge clk);
    n_chk++;
    if ({bus.busy, bus.err} !== 2'b10) begin
      n_fail++; $display("FAIL timeout_early: busy/err %b required 10", {bus.busy, bus.err});
    end
    repeat (10) @(negedge clk);
    n_chk++;
    if ({bus.err, bus.busy, bus.cpu_run} !== 3'b100) begin
      n_fail++; $display("FAIL timeout_status: err/busy/run %b required 100", {bus.err, bus.busy, bus.cpu_run});
    end
    n_chk++;
    if (wr_cnt != rd_ptr) begin n_fail++; $display("FAIL timeout_write: %0d writes, required 0", wr_cnt - rd_ptr); rd_ptr = wr_cnt; end
  endtask

  task automatic test_run_reload();
    logic [31:0] w[$];
    w = '{32'h00C0FFEE};
    send_frame(w, 8'h00);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_chk++;
      if (rd_ptr >= wr_cnt) begin n_fail++; $display("FAIL run_write: none, required %h", e); end
      else begin
        if (obs[rd_ptr] !== e) begin n_fail++; $display("FAIL run_write: got %h required %h", obs[rd_ptr], e); end
        rd_ptr++;
      end
    end
    send_byte(8'hA5);
    send_byte(8'h01);
    n_chk++;
    if ({bus.cpu_run, bus.busy} !== 2'b10) begin
      n_fail++; $display("FAIL run_ignore: run/busy %b required 10", {bus.cpu_run, bus.busy});
    end
    pulse_reload();
    n_chk++;
    if ({bus.cpu_run, bus.busy, bus.err} !== 3'b000) begin
      n_fail++; $display("FAIL reload_status: run/busy/err %b required 000", {bus.cpu_run, bus.busy, bus.err});
    end
    // Magic byte coincident with reload must be dropped.
    bus.rx_data  = 8'hA5;
    bus.rx_valid = 1'b1;
    bus.reload   = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.reload   = 1'b0;
    @(negedge clk);
    send_byte(8'h01);
    n_chk++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reload_drop: busy %b required 0", bus.busy); end
    n_chk++;
    if (wr_cnt != rd_ptr) begin n_fail++; $display("FAIL run_extra: %0d extra writes, required 0", wr_cnt - rd_ptr); rd_ptr = wr_cnt; end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] w[$];
    logic [7:0]  d[6];
    d = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h99, 8'h88};
    send_byte(8'hA5);
    send_byte(8'h02);
    exp_q.push_back({8'd0, 32'h11223344});
    foreach (d[i]) send_byte(d[i]);
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({bus.mem_we, bus.cpu_run, bus.busy, bus.err, bus.loaded_words, bus.mem_addr, bus.mem_wdata} !== '0) begin
      n_fail++; $display("FAIL async_reset: outputs %h required 0",
                         {bus.mem_we, bus.cpu_run, bus.busy, bus.err, bus.loaded_words, bus.mem_addr, bus.mem_wdata});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    w = '{32'h87654321, 32'h0F0F0F0F};
    send_frame(w, 8'h00);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_chk++;
      if (rd_ptr >= wr_cnt) begin n_fail++; $display("FAIL rst_write: none, required %h", e); end
      else begin
        if (obs[rd_ptr] !== e) begin n_fail++; $display("FAIL rst_write: got %h required %h", obs[rd_ptr], e); end
        rd_ptr++;
      end
    end
    n_chk++;
    if (wr_cnt != rd_ptr) begin n_fail++; $display("FAIL rst_extra: %0d extra writes, required 0", wr_cnt - rd_ptr); rd_ptr = wr_cnt; end
    n_chk++;
    if ({bus.cpu_run, bus.err, bus.loaded_words} !== {2'b10, 8'd2}) begin
      n_fail++; $display("FAIL rst_reload: run/err/loaded %b/%b/%0d required 1/0/2",
                         bus.cpu_run, bus.err, bus.loaded_words);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_count_bounds();
    test_timeout();
    test_run_reload();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
